// File: rtl/dm_cache_four_bank_sys.sv
// Direct-mapped write-back/write-allocate cache (256 lines x 4 words x 16 bit) with its miss FSM
// and a word-interleaved four-bank main memory (2-cycle read return, bank busy 4 cycles per access).
module dm_cache_four_bank_sys #(
  parameter int mem_type = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] Addr,
  input  logic [15:0] DataIn,
  input  logic        Rd,
  input  logic        Wr,
  input  logic        createdump,
  output logic [15:0] DataOut,
  output logic        Done,
  output logic        Stall,
  output logic        CacheHit,
  output logic        err
);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_WB0, S_WB1, S_WB2, S_WB3,
    S_RD0, S_RD1, S_RD2, S_RD3,
    S_INS2, S_INS3
  } state_e;

  state_e      state_q, state_d;
  logic [4:0]  req_tag;
  logic [7:0]  req_idx;
  logic [1:0]  req_word;
  logic        req, illegal, hit, victim_dirty;
  logic [3:0]  st_off;
  logic [1:0]  step_word;
  logic        wb_phase;

  logic [255:0] valid_q, dirty_q;
  logic [4:0]   tag_q [256];
  logic [15:0]  line_data [4];
  logic [3:0]   line_we;
  logic [15:0]  line_wdata [4];
  logic         hit_wr, fill_done;
  logic [15:0]  fill_word;

  logic [3:0]   bank_busy, mem_we, mem_re;
  logic [12:0]  bank_addr;
  logic [15:0]  bank_wdata;
  logic [15:0]  bank_rdata [4];
  logic         rd1_vld_q, rd2_vld_q;
  logic [1:0]   rd1_word_q, rd2_word_q;
  logic [15:0]  rd2_data_q;

  assign req_tag      = Addr[15:11];
  assign req_idx      = Addr[10:3];
  assign req_word     = Addr[2:1];
  assign req          = Rd | Wr;
  assign illegal      = (Rd & Wr) | Addr[0];
  assign hit          = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign victim_dirty = valid_q[req_idx] & dirty_q[req_idx];

  // WBk and RDk share the low two bits of their offset from S_WB0, giving the word/bank being moved.
  assign st_off     = state_q - S_WB0;
  assign step_word  = st_off[1:0];
  assign wb_phase   = state_q inside {S_WB0, S_WB1, S_WB2, S_WB3};
  assign bank_addr  = wb_phase ? {tag_q[req_idx], req_idx} : {req_tag, req_idx};
  assign bank_wdata = line_data[step_word];
  assign fill_word  = (req_word == 2'd3) ? rd2_data_q : line_data[req_word];

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    Done      = 1'b0;
    Stall     = 1'b0;
    CacheHit  = 1'b0;
    err       = 1'b0;
    DataOut   = '0;
    mem_we    = '0;
    mem_re    = '0;
    hit_wr    = 1'b0;
    fill_done = 1'b0;
    if (!rst) begin
      case (state_q)
        S_IDLE: begin
          if (req) begin
            if (illegal) begin
              err  = 1'b1;
              Done = 1'b1;
            end else if (hit) begin
              Done     = 1'b1;
              CacheHit = 1'b1;
              hit_wr   = Wr;
              if (Rd) DataOut = line_data[req_word];
            end else begin
              Stall   = 1'b1;
              state_d = victim_dirty ? S_WB0 : S_RD0;
            end
          end
        end
        S_WB0, S_WB1, S_WB2, S_WB3: begin
          Stall = 1'b1;
          if (!bank_busy[step_word]) begin
            mem_we  = 4'b0001 << step_word;
            state_d = state_e'(state_q + 4'd1);
          end
        end
        S_RD0, S_RD1, S_RD2, S_RD3: begin
          Stall = 1'b1;
          if (!bank_busy[step_word]) begin
            mem_re  = 4'b0001 << step_word;
            state_d = state_e'(state_q + 4'd1);
          end
        end
        S_INS2: begin
          Stall   = 1'b1;
          state_d = S_INS3;
        end
        S_INS3: begin
          Done      = 1'b1;
          fill_done = 1'b1;
          if (Rd) DataOut = fill_word;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Returned memory words install as they arrive; a write miss substitutes DataIn for its own word.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      line_we[i]    = (hit_wr && req_word == 2'(i)) || (rd2_vld_q && rd2_word_q == 2'(i));
      line_wdata[i] = (Wr && req_word == 2'(i)) ? DataIn : rd2_data_q;
    end
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_word
      logic [15:0] data_q [256];
      assign line_data[gi] = data_q[req_idx];
      always_ff @(posedge clk) begin
        if (!rst && line_we[gi]) data_q[req_idx] <= line_wdata[gi];
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      if (hit_wr) dirty_q[req_idx] <= 1'b1;
      if (fill_done) begin
        valid_q[req_idx] <= 1'b1;
        dirty_q[req_idx] <= Wr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && fill_done) tag_q[req_idx] <= req_tag;
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_bank
      logic [15:0] mem_q [8192];
      logic [15:0] rdata_q;
      logic [1:0]  busy_cnt_q;
      assign bank_busy[gi]  = (busy_cnt_q != 2'd0);
      assign bank_rdata[gi] = rdata_q;
      always_ff @(posedge clk) begin
        if (rst) begin
          busy_cnt_q <= 2'd0;
          rdata_q    <= '0;
          for (int j = 0; j < 8192; j++) mem_q[j] <= '0;
        end else begin
          if (mem_we[gi] || mem_re[gi]) busy_cnt_q <= 2'd3;
          else if (bank_busy[gi])       busy_cnt_q <= busy_cnt_q - 2'd1;
          if (mem_we[gi]) mem_q[bank_addr] <= bank_wdata;
          if (mem_re[gi]) rdata_q <= mem_q[bank_addr];
        end
      end
    end
  endgenerate

  // Second stage of the read return: data lands in the cache two cycles after issue.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd1_vld_q  <= 1'b0;
      rd2_vld_q  <= 1'b0;
      rd1_word_q <= 2'd0;
      rd2_word_q <= 2'd0;
      rd2_data_q <= '0;
    end else begin
      rd1_vld_q  <= |mem_re;
      rd1_word_q <= step_word;
      rd2_vld_q  <= rd1_vld_q;
      rd2_word_q <= rd1_word_q;
      rd2_data_q <= bank_rdata[rd1_word_q];
    end
  end

  logic unused_ok;
  assign unused_ok = ^{createdump, (mem_type != 0), st_off[3:2]};

endmodule

// File: tb/tb_dm_cache_four_bank_sys.sv
// Randomized bench for dm_cache_four_bank_sys against an array-based cache/memory reference model.
module tb_dm_cache_four_bank_sys;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] Addr, DataIn, DataOut;
  logic        Rd, Wr, createdump;
  logic        Done, Stall, CacheHit, err;

  int n_checks = 0;
  int n_errors = 0;
  int n_txn    = 0;

  bit [15:0] m_mem   [32768];
  bit        m_valid [256];
  bit        m_dirty [256];
  bit [4:0]  m_tag   [256];
  bit [15:0] m_line  [256][4];

  dm_cache_four_bank_sys #(.mem_type(1)) dut (
    .clk(clk), .rst(rst), .Addr(Addr), .DataIn(DataIn), .Rd(Rd), .Wr(Wr),
    .createdump(createdump), .DataOut(DataOut), .Done(Done), .Stall(Stall),
    .CacheHit(CacheHit), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32768; i++) m_mem[i] = '0;
    for (int i = 0; i < 256; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
      m_tag[i]   = '0;
      for (int w = 0; w < 4; w++) m_line[i][w] = '0;
    end
  endtask

  // Reference behaviour: plain line bookkeeping with whole-line writeback and refill.
  task automatic model_req(input bit rd, input bit wr, input logic [15:0] addr, input logic [15:0] din,
                           output logic [15:0] e_data, output bit e_hit, output bit e_err,
                           output int e_lat);
    int idx, tg, w;
    e_data = '0;
    e_hit  = 1'b0;
    e_err  = 1'b0;
    e_lat  = 0;
    if ((rd && wr) || addr[0]) begin
      e_err = 1'b1;
      return;
    end
    tg  = int'(addr[15:11]);
    idx = int'(addr[10:3]);
    w   = int'(addr[2:1]);
    if (m_valid[idx] && int'(m_tag[idx]) == tg) begin
      e_hit = 1'b1;
    end else begin
      e_lat = (m_valid[idx] && m_dirty[idx]) ? 10 : 6;
      if (m_valid[idx] && m_dirty[idx])
        for (int j = 0; j < 4; j++) m_mem[int'(m_tag[idx]) * 1024 + idx * 4 + j] = m_line[idx][j];
      for (int j = 0; j < 4; j++) m_line[idx][j] = m_mem[tg * 1024 + idx * 4 + j];
      m_valid[idx] = 1'b1;
      m_dirty[idx] = 1'b0;
      m_tag[idx]   = 5'(tg);
    end
    if (wr) begin
      m_line[idx][w] = din;
      m_dirty[idx]   = 1'b1;
    end
    if (rd) e_data = m_line[idx][w];
  endtask

  task automatic check_idle(input string tag);
    check_eq(tag, {DataOut, 12'd0, Done, Stall, CacheHit, err}, 32'd0);
  endtask

  task automatic do_req(input bit rd, input bit wr, input logic [15:0] addr, input logic [15:0] din);
    logic [15:0] e_data;
    bit          e_hit, e_err, got;
    int          e_lat, cyc;
    @(posedge clk);
    #1;
    Rd = rd; Wr = wr; Addr = addr; DataIn = din;
    model_req(rd, wr, addr, din, e_data, e_hit, e_err, e_lat);
    cyc = 0;
    got = 1'b0;
    while (!got && cyc <= 40) begin
      @(negedge clk);
      if (Done) got = 1'b1;
      else begin
        check_eq("stall_busy", 32'(Stall), 32'd1);
        cyc++;
      end
    end
    check_eq("done_seen", 32'(got), 32'd1);
    if (got) begin
      check_eq("latency", 32'(cyc), 32'(e_lat));
      check_eq("dataout", 32'(DataOut), 32'(e_data));
      check_eq("cachehit", 32'(CacheHit), 32'(e_hit));
      check_eq("err", 32'(err), 32'(e_err));
      check_eq("stall_at_done", 32'(Stall), 32'd0);
    end
    $display("txn %0d rd=%0b wr=%0b addr=0x%04h din=0x%04h -> cycles=%0d data=0x%04h hit=%0b err=%0b",
             n_txn, rd, wr, addr, din, cyc, DataOut, CacheHit, err);
    n_txn++;
    @(posedge clk);
    #1;
    Rd = 1'b0; Wr = 1'b0;
    @(negedge clk);
    check_idle("idle_after_txn");
  endtask

  initial begin
    logic [15:0] a, d;
    bit          rd, wr;
    int          r;
    rst = 1'b1; Rd = 1'b0; Wr = 1'b0; Addr = '0; DataIn = '0; createdump = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle("reset_outputs");
    rst = 1'b0;
    @(negedge clk);
    check_idle("post_reset_idle");

    do_req(1, 0, 16'h0010, 16'h0000);
    do_req(0, 1, 16'h0012, 16'hBEEF);
    do_req(1, 0, 16'h0012, 16'h0000);
    do_req(1, 0, 16'h0812, 16'h0000);
    do_req(1, 0, 16'h0012, 16'h0000);
    do_req(0, 1, 16'h4006, 16'h1234);
    do_req(1, 0, 16'h4006, 16'h0000);
    do_req(1, 0, 16'h0001, 16'h0000);
    do_req(1, 1, 16'h4006, 16'h5555);
    do_req(1, 0, 16'h4006, 16'h0000);

    // Reset in the RD2 cycle of a clean miss.
    @(posedge clk);
    #1;
    Rd = 1'b1; Addr = 16'h2010;
    repeat (4) @(negedge clk);
    check_eq("stall_in_rd2", 32'(Stall), 32'd1);
    rst = 1'b1; Rd = 1'b0;
    @(negedge clk);
    check_idle("outputs_during_rst");
    rst = 1'b0;
    @(negedge clk);
    check_idle("outputs_after_rst");
    model_reset();
    do_req(1, 0, 16'h0012, 16'h0000);
    do_req(1, 0, 16'h4006, 16'h0000);

    for (int i = 0; i < 250; i++) begin
      r = $urandom_range(0, 99);
      a = {5'($urandom_range(0, 3)), 8'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 1'b0};
      if ($urandom_range(0, 9) == 0) a[10:3] = 8'hFF;
      d  = 16'($urandom);
      wr = 1'($urandom_range(0, 1));
      rd = ~wr;
      if (r < 4) a[0] = 1'b1;
      else if (r < 7) begin
        rd = 1'b1;
        wr = 1'b1;
      end
      do_req(rd, wr, a, d);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
